// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared constants for the DES key schedule:
//     - FSM state encoding (localparams plus the state_t enum built on them)
//     - PC-1 table (56 entries), PC-2 table (48 entries), 16-entry shift schedule
//     - helpers: pc1_permute (64-bit key -> 56-bit C||D), rotl28 (28-bit rotate)
//   Bit numbering follows DES: table entry n names DES bit n, and DES bit 1 is
//   the MSB of the vector it indexes.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int N_ROUNDS     = 16;
    localparam int SUBKEY_W     = 48;
    localparam int ROUND_KEYS_W = N_ROUNDS * SUBKEY_W;  // 768

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        GEN  = ST_GEN,
        DONE = ST_DONE
    } state_t;

    // PC-1: selects 56 of the 64 key bits (parity bits 8,16,..,64 never appear).
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: selects 48 of the 56 C||D bits to form a subkey.
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied to C and D before round r+1's subkey.
    localparam int SHIFT_TBL [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    function automatic logic [55:0] pc1_permute(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55 - i] = key[64 - PC1_TBL[i]];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

endpackage

// File: rtl/key_schedule_if.sv
// -----------------------------------------------------------------------------
// key_schedule_if
//   Request/response bundle between a key-schedule client and key_schedule.
//     start      : request a new schedule (taken only while ready=1)
//     key        : 64-bit DES key, bit 63 = DES bit 1, sampled with start
//     decrypt    : reverse slot order (only with KEY_SCHEDULE_DECRYPT_EN)
//     ready      : generator can accept start (IDLE or DONE)
//     keys_valid : round_keys holds a complete schedule
//     round_keys : 16 x 48-bit subkeys, slot 0 in bits [767:720]
//   Modports: master = client side, slave = key_schedule side.
//   Optional build macro: KEY_SCHEDULE_DECRYPT_EN.
// -----------------------------------------------------------------------------
interface key_schedule_if;
    import des_pkg::*;

    logic                    start;
    logic [63:0]             key;
`ifdef KEY_SCHEDULE_DECRYPT_EN
    logic                    decrypt;
`endif
    logic                    ready;
    logic                    keys_valid;
    logic [ROUND_KEYS_W-1:0] round_keys;

`ifdef KEY_SCHEDULE_DECRYPT_EN
    modport master (output start, key, decrypt, input ready, keys_valid, round_keys);
    modport slave  (input start, key, decrypt, output ready, keys_valid, round_keys);
`else
    modport master (output start, key, input ready, keys_valid, round_keys);
    modport slave  (input start, key, output ready, keys_valid, round_keys);
`endif

endinterface

// File: rtl/key_sched_pc2.sv
// -----------------------------------------------------------------------------
// key_sched_pc2
//   Combinational PC-2 permutation.
//     cd     : 56-bit C||D (C in [55:28], DES bit 1 at bit 55)
//     subkey : 48-bit round subkey (DES bit 1 at bit 47)
// -----------------------------------------------------------------------------
module key_sched_pc2
    import des_pkg::*;
(
    input  logic [55:0]         cd,
    output logic [SUBKEY_W-1:0] subkey
);

    always_comb begin
        // NOTE: a default before the loop keeps every bit assigned on every
        // path, so no latch can be inferred.
        subkey = '0;
        for (int j = 0; j < SUBKEY_W; j++) begin
            subkey[SUBKEY_W - 1 - j] = cd[56 - PC2_TBL[j]];
        end
    end

endmodule

// File: rtl/key_schedule.sv
// -----------------------------------------------------------------------------
// key_schedule
//   DES key schedule generator: one subkey per clock, 16 clocks per schedule.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset (forces IDLE, clears all state)
//     bus : key_schedule_if.slave (start/key[/decrypt] in,
//           ready/keys_valid/round_keys out)
//   Flow: IDLE/DONE --start--> GEN (16 edges, one slot each) --> DONE.
//   Optional build macro: KEY_SCHEDULE_DECRYPT_EN adds bus.decrypt, which
//   stores round r in slot 16-r instead of r-1; timing is unchanged.
// -----------------------------------------------------------------------------
module key_schedule
    import des_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    key_schedule_if.slave bus
);

    state_t                       state_q, state_d;
    logic [3:0]                   round_q;
    logic [27:0]                  c_q, d_q;
    logic [27:0]                  c_rot, d_rot;
    logic [55:0]                  cd_load;
    logic [SUBKEY_W-1:0]          subkey;
    logic [0:N_ROUNDS-1][SUBKEY_W-1:0] keys_q;   // keys_q[0] is the MSB slot
    logic [3:0]                   slot;
    logic                         ready;
    logic                         accept;
    logic                         two_shift;

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign accept = ready && bus.start;

    // Rotation for the round about to be produced (round_q+1).
    assign two_shift = (SHIFT_TBL[round_q] == 2);
    assign c_rot     = rotl28(c_q, two_shift);
    assign d_rot     = rotl28(d_q, two_shift);
    assign cd_load   = pc1_permute(bus.key);

    key_sched_pc2 u_pc2 (
        .cd     ({c_rot, d_rot}),
        .subkey (subkey)
    );

`ifdef KEY_SCHEDULE_DECRYPT_EN
    logic decrypt_q;
    assign slot = decrypt_q ? (4'd15 - round_q) : round_q;
`else
    assign slot = round_q;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: flops are written with <= so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = GEN;
            GEN:        if (round_q == 4'd15) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    // NOTE: the subkey store is a flop array, not a RAM, so it takes the
    // asynchronous reset like everything else; partial keys must not survive
    // a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= '0;
            c_q     <= '0;
            d_q     <= '0;
            keys_q  <= '0;
`ifdef KEY_SCHEDULE_DECRYPT_EN
            decrypt_q <= 1'b0;
`endif
        end else if (accept) begin
            c_q     <= cd_load[55:28];
            d_q     <= cd_load[27:0];
            round_q <= '0;
            keys_q  <= '0;
`ifdef KEY_SCHEDULE_DECRYPT_EN
            decrypt_q <= bus.decrypt;
`endif
        end else if (state_q == GEN) begin
            c_q          <= c_rot;
            d_q          <= d_rot;
            keys_q[slot] <= subkey;
            round_q      <= round_q + 4'd1;
        end
    end

    assign bus.ready      = ready;
    assign bus.keys_valid = (state_q == DONE);
    assign bus.round_keys = keys_q;

endmodule

// File: tb/tb_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_key_schedule
//   Self-checking bench for key_schedule. Expected schedules come from known
//   DES vectors and from a reference model that applies PC-1, cumulative
//   rotations and PC-2 directly from the DES tables.
// -----------------------------------------------------------------------------
module tb_key_schedule;

    logic clk = 1'b0;
    logic rst;

    key_schedule_if ifc ();

    key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DES tables (DES bit numbering, bit 1 = MSB) ----------------
    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                       16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                       44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Reference: C_r[i] = C_0[(i + total_shift) mod 28], same for D.
    function automatic logic [767:0] model(input logic [63:0] k, input bit rev);
        bit          cd0 [56];
        logic [767:0] out;
        logic [47:0]  sub;
        int           tot, p, slot;
        out = '0;
        for (int i = 0; i < 56; i++) cd0[i] = k[64 - pc1_t[i]];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += sh_t[r];
            for (int j = 0; j < 48; j++) begin
                p = pc2_t[j] - 1;
                if (p < 28) sub[47 - j] = cd0[(p + tot) % 28];
                else        sub[47 - j] = cd0[28 + ((p - 28 + tot) % 28)];
            end
            slot = rev ? 15 - r : r;
            out[767 - 48*slot -: 48] = sub;
        end
        return out;
    endfunction

    function automatic logic [767:0] partial(input logic [767:0] full, input int n);
        logic [767:0] o;
        o = full;
        for (int s = n; s < 16; s++) o[767 - 48*s -: 48] = '0;
        return o;
    endfunction

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_gen(input logic [63:0] k, input bit rev);
        ifc.start = 1'b1;
        ifc.key   = k;
`ifdef KEY_SCHEDULE_DECRYPT_EN
        ifc.decrypt = rev;
`endif
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.key   = {$urandom, $urandom};
`ifdef KEY_SCHEDULE_DECRYPT_EN
        ifc.decrypt = ~rev;
`endif
        check("gen_ready",      ifc.ready,      0);
        check("gen_keys_valid", ifc.keys_valid, 0);
        check("gen_cleared",    ifc.round_keys, 0);
    endtask

    // Counts edges after the accept edge until keys_valid, bounded.
    task automatic wait_valid(input int from, input string name);
        int edges;
        edges = from;
        while (ifc.keys_valid !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_latency"}, edges, 16);
        check({name, "_ready"},   ifc.ready, 1);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [47:0] slot0;
        logic [47:0] slot15;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0]  ka, kb;
        logic [767:0] snap;

        vecs[0] = '{64'h133457799BBCDFF1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{64'h123456789ABCDEF0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[2] = '{64'h0000000000000000, 48'h000000000000, 48'h000000000000};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.key   = '0;
`ifdef KEY_SCHEDULE_DECRYPT_EN
        ifc.decrypt = 1'b0;
`endif
        #3;
        check("rst_ready",      ifc.ready,      1);
        check("rst_keys_valid", ifc.keys_valid, 0);
        check("rst_round_keys", ifc.round_keys, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors; first start goes in on the first edge after reset.
        for (int v = 0; v < 4; v++) begin
            start_gen(vecs[v].key, 1'b0);
            wait_valid(0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_slot0", v),  ifc.round_keys[767 -: 48], vecs[v].slot0);
            check($sformatf("vec%0d_slot15", v), ifc.round_keys[47:0],      vecs[v].slot15);
            check($sformatf("vec%0d_full", v),   ifc.round_keys, model(vecs[v].key, 1'b0));
        end

        // Random keys against the reference model.
        for (int t = 0; t < 8; t++) begin
            ka = {$urandom, $urandom};
            start_gen(ka, 1'b0);
            wait_valid(0, $sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_full", t), ifc.round_keys, model(ka, 1'b0));
        end

        // DONE holds indefinitely.
        snap = model(ka, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_valid", ifc.keys_valid, 1);
        check("hold_keys",  ifc.round_keys, snap);

        // Start during GEN is ignored; latency counted from the first accept.
        ka = 64'h133457799BBCDFF1;
        kb = 64'h0E329232EA6D0D73;
        start_gen(ka, 1'b0);
        repeat (5) @(negedge clk);
        ifc.start = 1'b1;
        ifc.key   = kb;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_valid(6, "busy");
        check("busy_full", ifc.round_keys, model(ka, 1'b0));

        // Restart from DONE with a different key.
        start_gen(kb, 1'b0);
        wait_valid(0, "restart");
        check("restart_full", ifc.round_keys, model(kb, 1'b0));

        // Reset in the middle of GEN.
        ka = {$urandom, $urandom};
        start_gen(ka, 1'b0);
        repeat (8) @(negedge clk);
        check("mid_partial", ifc.round_keys, partial(model(ka, 1'b0), 8));
        #1 rst = 1'b1;
        #1;
        check("midrst_ready",      ifc.ready,      1);
        check("midrst_keys_valid", ifc.keys_valid, 0);
        check("midrst_round_keys", ifc.round_keys, 0);
        @(negedge clk);
        rst = 1'b0;
        start_gen(kb, 1'b0);
        wait_valid(0, "after_rst");
        check("after_rst_full", ifc.round_keys, model(kb, 1'b0));

`ifdef KEY_SCHEDULE_DECRYPT_EN
        start_gen(64'h133457799BBCDFF1, 1'b1);
        wait_valid(0, "dec");
        check("dec_slot0",  ifc.round_keys[767 -: 48], 48'hCB3D8B0E17F5);
        check("dec_slot15", ifc.round_keys[47:0],      48'h1B02EFFC7072);
        ka = {$urandom, $urandom};
        start_gen(ka, 1'b1);
        wait_valid(0, "dec_rnd");
        check("dec_rnd_full", ifc.round_keys, model(ka, 1'b1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
